// File: rtl/sram_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | sram_port_arbiter: shares one SRAM-like port between inst and data sides,  |
// | with an in-order tag FIFO to route responses back. Option: ARB_RR_EN.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module sram_port_arbiter #(
  parameter int MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_NONE   = 2'd0;
  localparam logic [1:0] S_LOCK_I = 2'd1;
  localparam logic [1:0] S_LOCK_D = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          w_grant_i;
  logic          w_grant_d;
  logic          w_room;
  logic          w_pick_d;
  logic          w_push;
  logic          w_pop;
  logic          w_head;
  logic          r_tag [MAX_OUTST];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

`ifdef ARB_RR_EN
  logic r_last_d;

  // On contention, favour whichever side did not win the last handshake.
  assign w_pick_d = !r_last_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     r_last_d <= 1'b0;
    else if (w_push) r_last_d <= w_grant_d;
  end
`else
  assign w_pick_d = 1'b1;
`endif

  // The last free slot is only handed out when a response frees one that cycle.
  assign w_room = !(r_count == CW'(MAX_OUTST)) &&
                  !((r_count == CW'(MAX_OUTST - 1)) && !mem_data_ok);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_NONE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOCK_I, S_LOCK_D: if (mem_addr_ok) w_state_nxt = S_NONE;
      default: begin
        w_state_nxt = S_NONE;
        if (w_grant_d && !mem_addr_ok)      w_state_nxt = S_LOCK_D;
        else if (w_grant_i && !mem_addr_ok) w_state_nxt = S_LOCK_I;
      end
    endcase
  end

  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (resetn) begin
      case (r_state)
        S_LOCK_I: w_grant_i = 1'b1;
        S_LOCK_D: w_grant_d = 1'b1;
        default: begin
          if (w_room) begin
            w_grant_d = data_req & (!inst_req | w_pick_d);
            w_grant_i = inst_req & !(data_req & (!inst_req | w_pick_d));
          end
        end
      endcase
    end
  end

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_wstrb = 4'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (w_grant_d) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else if (w_grant_i) begin
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_wstrb = inst_wstrb;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end
  end

  assign mem_req      = (w_grant_i & inst_req) | (w_grant_d & data_req);
  assign inst_addr_ok = mem_addr_ok & mem_req & w_grant_i;
  assign data_addr_ok = mem_addr_ok & mem_req & w_grant_d;

  assign w_push = mem_req & mem_addr_ok;
  assign w_pop  = mem_data_ok & (r_count != '0);
  assign w_head = r_tag[r_rd_ptr];

  assign inst_data_ok = w_pop & !w_head;
  assign data_data_ok = w_pop & w_head;
  assign inst_rdata   = inst_data_ok ? mem_rdata : 32'd0;
  assign data_rdata   = data_data_ok ? mem_rdata : 32'd0;

  always_ff @(posedge clk) begin
    if (w_push) r_tag[r_wr_ptr] <= w_grant_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed vector table, reset-mid-lock sequence,
// then protocol-legal random traffic against a queue-based reference model.
`default_nettype none

module tb_sram_port_arbiter;
  localparam int MAX = 4;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [31:0] IA = 32'h1c00_0000;
  localparam logic [31:0] DA = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  sram_port_arbiter #(.MAX_OUTST(MAX)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // in_f = {inst_req, data_req, mem_addr_ok, mem_data_ok}
  // ex_f = {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
  typedef struct {
    logic [3:0]  in_f;
    logic [31:0] rd;
    logic [4:0]  ex_f;
    logic [31:0] maddr;
    logic [31:0] irdata;
    logic [31:0] drdata;
  } vec_t;

  vec_t tbl [20];

  // Reference model state: lock side (-1 none, 0 inst, 1 data), last winner, tag queue.
  int m_lock;
  int m_last;
  int q[$];

  function automatic int model_grant(input logic ir, input logic dr, input logic dok);
    bit room;
    if (!resetn) return -1;
    if (m_lock >= 0) return m_lock;
    room = (q.size() < MAX - 1) || (q.size() == MAX - 1 && dok);
    if (!room) return -1;
    if (ir && dr) return RR ? (m_last == 0 ? 1 : 0) : 1;
    if (dr) return 1;
    if (ir) return 0;
    return -1;
  endfunction

  initial begin
    tbl[0]  = '{4'b0000, 32'h00, 5'b00000, 32'h0, 32'h00, 32'h00};
    tbl[1]  = '{4'b0001, 32'h55, 5'b00000, 32'h0, 32'h00, 32'h00};
    tbl[2]  = '{4'b1110, 32'h00, 5'b10100, DA,    32'h00, 32'h00};
    tbl[3]  = '{4'b1010, 32'h00, 5'b11000, IA,    32'h00, 32'h00};
    tbl[4]  = '{4'b0001, 32'hA1, 5'b00001, 32'h0, 32'h00, 32'hA1};
    tbl[5]  = '{4'b0001, 32'hB2, 5'b00010, 32'h0, 32'hB2, 32'h00};
    tbl[6]  = '{4'b0001, 32'h77, 5'b00000, 32'h0, 32'h00, 32'h00};
    tbl[7]  = '{4'b0100, 32'h00, 5'b10000, DA,    32'h00, 32'h00};
    tbl[8]  = '{4'b0100, 32'h00, 5'b10000, DA,    32'h00, 32'h00};
    tbl[9]  = '{4'b0100, 32'h00, 5'b10000, DA,    32'h00, 32'h00};
    tbl[10] = '{4'b1100, 32'h00, 5'b10000, DA,    32'h00, 32'h00};
    tbl[11] = '{4'b1110, 32'h00, 5'b10100, DA,    32'h00, 32'h00};
    tbl[12] = '{4'b1010, 32'h00, 5'b11000, IA,    32'h00, 32'h00};
    tbl[13] = '{4'b1010, 32'h00, 5'b11000, IA,    32'h00, 32'h00};
    tbl[14] = '{4'b0110, 32'h00, 5'b00000, 32'h0, 32'h00, 32'h00};
    tbl[15] = '{4'b0111, 32'h11, 5'b10101, DA,    32'h00, 32'h11};
    tbl[16] = '{4'b0001, 32'h22, 5'b00010, 32'h0, 32'h22, 32'h00};
    tbl[17] = '{4'b0001, 32'h33, 5'b00010, 32'h0, 32'h33, 32'h00};
    tbl[18] = '{4'b0001, 32'h44, 5'b00001, 32'h0, 32'h00, 32'h44};
    tbl[19] = '{4'b0001, 32'h99, 5'b00000, 32'h0, 32'h00, 32'h00};

    resetn = 1'b0;
    {inst_req, data_req, mem_addr_ok, mem_data_ok} = 4'b0000;
    inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hf; inst_addr = IA; inst_wdata = 32'h0;
    data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'h3; data_addr = DA; data_wdata = 32'hdeadbeef;
    mem_rdata = 32'h0;
    next_cycle();
    next_cycle();
    chk("reset_oks", {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
    chk("reset_payload", {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}, 0);
    resetn = 1'b1;
    next_cycle();

    // Directed vectors: priority, lock hold, FIFO order, full blocking, empty pop.
    for (int i = 0; i < 20; i++) begin
      {inst_req, data_req, mem_addr_ok, mem_data_ok} = tbl[i].in_f;
      mem_rdata = tbl[i].rd;
      @(negedge clk);
      chk($sformatf("vec%0d_flags", i),
          {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, tbl[i].ex_f);
      chk($sformatf("vec%0d_addr", i), mem_addr, tbl[i].maddr);
      chk($sformatf("vec%0d_rdata", i), {inst_rdata, data_rdata}, {tbl[i].irdata, tbl[i].drdata});
      next_cycle();
    end

    // Reset while data is locked with one inst tag outstanding.
    {inst_req, data_req, mem_addr_ok, mem_data_ok} = 4'b1010;
    @(negedge clk);
    chk("rst_pre_iaok", inst_addr_ok, 1);
    next_cycle();
    {inst_req, data_req, mem_addr_ok, mem_data_ok} = 4'b0100;
    @(negedge clk);
    chk("rst_lock_addr", mem_addr, DA);
    next_cycle();
    {inst_req, data_req, mem_addr_ok, mem_data_ok} = 4'b1111;
    mem_rdata = 32'h5a5a;
    resetn = 1'b0;
    #1;
    chk("rst_mid_oks", {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
    chk("rst_mid_payload", {mem_addr, inst_rdata, data_rdata}, 0);
    next_cycle();
    resetn = 1'b1;
    {inst_req, data_req, mem_addr_ok, mem_data_ok} = 4'b1001;
    @(negedge clk);
    chk("rst_after_addr", {mem_req, mem_addr}, {1'b1, IA});
    chk("rst_after_dok", {inst_data_ok, data_data_ok}, 0);
    next_cycle();

    // Random protocol-legal traffic against the reference model.
    resetn = 1'b0;
    {inst_req, data_req, mem_addr_ok, mem_data_ok} = 4'b0000;
    next_cycle();
    resetn = 1'b1;
    m_lock = -1;
    m_last = 0;
    q.delete();
    begin
      bit hold_i = 1'b0;
      bit hold_d = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        int g;
        logic        e_req, e_iaok, e_daok, e_idok, e_ddok;
        logic [70:0] e_pay;
        logic [31:0] e_ird, e_drd;
        if (!hold_i) begin
          inst_req = ($urandom_range(0, 2) != 0);
          inst_wr = 1'($urandom); inst_size = 2'($urandom_range(0, 2));
          inst_wstrb = 4'($urandom); inst_addr = $urandom; inst_wdata = $urandom;
          hold_i = inst_req;
        end
        if (!hold_d) begin
          data_req = ($urandom_range(0, 2) != 0);
          data_wr = 1'($urandom); data_size = 2'($urandom_range(0, 2));
          data_wstrb = 4'($urandom); data_addr = $urandom; data_wdata = $urandom;
          hold_d = data_req;
        end
        mem_addr_ok = ($urandom_range(0, 1) != 0);
        mem_data_ok = ($urandom_range(0, 9) < 4);
        mem_rdata = $urandom;
        @(negedge clk);

        g = model_grant(inst_req, data_req, mem_data_ok);
        e_req = (g == 0) ? inst_req : (g == 1) ? data_req : 1'b0;
        e_pay = (g == 1) ? {data_wr, data_size, data_wstrb, data_addr, data_wdata} :
                (g == 0) ? {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata} : '0;
        e_iaok = e_req && mem_addr_ok && g == 0;
        e_daok = e_req && mem_addr_ok && g == 1;
        e_idok = mem_data_ok && q.size() > 0 && q[0] == 0;
        e_ddok = mem_data_ok && q.size() > 0 && q[0] == 1;
        e_ird = e_idok ? mem_rdata : 32'h0;
        e_drd = e_ddok ? mem_rdata : 32'h0;

        chk("rnd_mem_req", mem_req, e_req);
        chk("rnd_payload", {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}, e_pay);
        chk("rnd_addr_ok", {inst_addr_ok, data_addr_ok}, {e_iaok, e_daok});
        chk("rnd_data_ok", {inst_data_ok, data_data_ok}, {e_idok, e_ddok});
        chk("rnd_rdata", {inst_rdata, data_rdata}, {e_ird, e_drd});

        if (mem_data_ok && q.size() > 0) void'(q.pop_front());
        if (e_req && mem_addr_ok) begin
          q.push_back(g);
          m_last = g;
        end
        if (m_lock < 0) begin
          if (g >= 0 && !mem_addr_ok) m_lock = g;
        end else if (mem_addr_ok) begin
          m_lock = -1;
        end
        if (e_iaok) hold_i = 1'b0;
        if (e_daok) hold_d = 1'b0;
        next_cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
